// File: rtl/reg_file_mp_if.sv
// Register-file access bundle: read ports, two writeback lanes, reservation, conflict flag.
// Latency: n/a (signal bundle only).
// Backpressure: none; every request is accepted in the cycle it is presented.
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr0_en;
    logic [ADDR_W-1:0]        wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [ADDR_W-1:0]        wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     wr_conflict;

    // Issue/writeback side drives requests and observes read results.
    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, wr_conflict
    );

    // Register file side.
    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, wr_conflict
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file (NUM_RD reads, 2 writes) with per-register busy scoreboard.
// Latency: reads combinational (0 cycles); writes/busy visible next cycle, or same cycle with RF_BYPASS_EN.
// Backpressure: none; all reads, writes and reservations are accepted every cycle.
module reg_file_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG0 = 1
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_mp_if.slave  rf
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]        mem [NUM_REGS];
    logic [NUM_REGS-1:0]      busy;
    logic                     conflict_q;
    logic                     wr0_act;
    logic                     wr1_act;
    logic                     rsv_act;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;
    logic [ADDR_W-1:0]        ra;
    logic [DATA_W-1:0]        rdv;
    logic                     rbv;

    // Register 0 is a hardwired zero when ZERO_REG0 is set: it swallows writes and reservations.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG0 != 0) && (a == '0);
    endfunction

    assign wr0_act = rf.wr0_en && !is_zero_reg(rf.wr0_addr);
    assign wr1_act = rf.wr1_en && !is_zero_reg(rf.wr1_addr);
    assign rsv_act = rf.rsv_en && !is_zero_reg(rf.rsv_addr);

    // Storage update; lane 1 is applied last so it wins a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            if (wr0_act) mem[rf.wr0_addr] <= rf.wr0_data;
            if (wr1_act) mem[rf.wr1_addr] <= rf.wr1_data;
        end
    end

    // Scoreboard: writebacks clear, a reservation applied last re-arms for the new producer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (wr0_act) busy[rf.wr0_addr] <= 1'b0;
            if (wr1_act) busy[rf.wr1_addr] <= 1'b0;
            if (rsv_act) busy[rf.rsv_addr] <= 1'b1;
        end
    end

    // One-cycle flag when both lanes land on the same real register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= wr0_act && wr1_act && (rf.wr0_addr == rf.wr1_addr);
        end
    end

    // Combinational read ports with optional write-through bypass; reset forces all-zero outputs.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ra        = '0;
        rdv       = '0;
        rbv       = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra  = rf.rd_addr[i*ADDR_W +: ADDR_W];
            rdv = mem[ra];
            rbv = busy[ra];
`ifdef RF_BYPASS_EN
            if (wr0_act && (rf.wr0_addr == ra)) begin
                rdv = rf.wr0_data;
                rbv = 1'b0;
            end
            if (wr1_act && (rf.wr1_addr == ra)) begin
                rdv = rf.wr1_data;
                rbv = 1'b0;
            end
`endif
            if (reset || is_zero_reg(ra)) begin
                rdv = '0;
                rbv = 1'b0;
            end
            rd_data_c[i*DATA_W +: DATA_W] = rdv;
            rd_busy_c[i]                  = rbv;
        end
    end

    assign rf.rd_data     = rd_data_c;
    assign rf.rd_busy     = rd_busy_c;
    assign rf.wr_conflict = conflict_q;
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file, successor to the single-write/dual-read integer register file. Provides NUM_RD combinational read ports and two write ports with same-cycle write-through bypass. Also keeps a per-register busy scoreboard so issue logic can detect pending writebacks. Sits between decode/issue (reads, reservations) and the two writeback lanes.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth NUM_REGS = 2**ADDR_W (localparam)
NUM_RD, 2, number of read ports (>=1)
ZERO_REG0, 1, 1 = register 0 hardwired to zero, never busy, writes ignored

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  busy flag of the register addressed by port i
wr0_en  in  1  write lane 0 enable
wr0_addr  in  ADDR_W  write lane 0 address
wr0_data  in  DATA_W  write lane 0 data
wr1_en  in  1  write lane 1 enable
wr1_addr  in  ADDR_W  write lane 1 address
wr1_data  in  DATA_W  write lane 1 data
rsv_en  in  1  reserve (mark busy) request
rsv_addr  in  ADDR_W  register to mark busy
wr_conflict  out  1  registered one-cycle pulse: both lanes wrote the same register

Behaviour:
- One clock (clk). reset is asynchronous and active-high.
- Reset (async assert, sync to next edge on deassert):
  - all registers = 0, all busy bits = 0, wr_conflict = 0.
  - While reset is high, bypass is disabled; rd_data = 0 and rd_busy = 0 on every port.
- Writes: on a rising edge, lane k with wrk_en=1 stores wrk_data at wrk_addr.
  - Both lanes to the same address: lane 1 wins.
  - wr_conflict = 1 in the following cycle only; no pulse if the address is 0 and ZERO_REG0=1.
- Reads are combinational, zero-cycle latency:
  - rd_data[i] = storage[rd_addr[i]], overridden by bypass (see Optional Feature).
  - ZERO_REG0=1: address 0 always reads 0, rd_busy = 0; writes and reservations to address 0 are dropped.
- Busy scoreboard, one bit per register, updated on the rising edge:
  - rsv_en sets busy[rsv_addr].
  - Any enabled write clears busy[wrk_addr].
  - Reserve and write to the same address in the same cycle: reserve wins, busy stays 1 (new producer issued).
  - rd_busy[i] = busy[rd_addr[i]], subject to bypass masking.
- Any number of read ports may address the same register; all return identical data.
- No other internal state; no FSM beyond storage and busy bits. No X propagation from unwritten registers (reset cleared).

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: if rd_addr[i] matches an enabled write address in the current cycle, rd_data[i] returns that write's data (lane 1 priority over lane 0) and rd_busy[i] is forced 0.
- Not defined: reads always return pre-edge storage contents, and rd_busy[i] reflects the stored busy bit even during a same-cycle write. New data is visible one cycle after the write edge.
- Port list is identical in both builds.

Test Plan:
1. Assert reset mid-run after writing reg 10 = 100 -> rd_data on all ports = 0 immediately (async); after release, reading reg 10 returns 0, rd_busy = 0, wr_conflict = 0.
2. wr0 reg 10 = 100, then read rd_addr = {2,10} -> rd_data = {0,100}. Next, wr1 reg 2 = 50 -> reading {2,10} returns {50,100}.
3. Same cycle wr0 reg 5 = 0x11 and wr1 reg 5 = 0x22 -> reg 5 reads 0x22 afterward; wr_conflict = 1 for exactly one cycle. Repeat with address 0 -> reads 0, no pulse.
4. Bypass: rd_addr[0] = 7 while wr0 reg 7 = 0xDEAD -> same-cycle rd_data[0] = 0xDEAD with RF_BYPASS_EN, old value 0 without it; next cycle 0xDEAD in both builds.
5. Scoreboard: rsv reg 3 -> rd_busy = 1 the next cycle. Write reg 3 -> busy clears. Same-cycle rsv + write reg 3 -> busy stays 1. rsv reg 0 -> rd_busy stays 0.
6. NUM_RD = 4, DATA_W = 64 build: all four ports read reg 31 = 64'hFFFF_0000_1234_5678 -> identical data on every port.
